// File: rtl/pool_pack_out.sv
// Packs addressed bytes into per-slot words and flags into flag words, buffered by two FWFT FIFOs.
// Optional POOL_PACK_CNT_EN adds blk_cnt, a saturating count of data words popped per layer.
module pool_pack_out #(
  parameter int unsigned PORT_WIDTH = 128,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FLAG_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FIFO_AW    = 6,
  parameter int unsigned BURST      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  layer_fnh,
  output logic                  clear_up,
  input  logic                  BF_val,
  output logic                  BF_rdy,
  input  logic [ADDR_WIDTH-1:0] BF_addr,
  input  logic [DATA_WIDTH-1:0] BF_data,
  input  logic                  BF_flg_val,
  output logic                  BF_flg_rdy,
  input  logic [FLAG_WIDTH-1:0] BF_flg_data,
  output logic                  POOLIF_val,
  input  logic                  IFPOOL_rdy,
  output logic [PORT_WIDTH-1:0] POOLIF_data,
  output logic                  POOLIF_flg_val,
  input  logic                  IFPOOL_flg_rdy,
  output logic [PORT_WIDTH-1:0] POOLIF_flg_data
`ifdef POOL_PACK_CNT_EN
  ,
  output logic [15:0]           blk_cnt
`endif
);

  localparam int unsigned LANES  = PORT_WIDTH / DATA_WIDTH;
  localparam int unsigned FPW    = PORT_WIDTH / FLAG_WIDTH;
  localparam int unsigned SLOTS  = 1 << ADDR_WIDTH;
  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned FILL_W = $clog2(LANES);
  localparam int unsigned FCW    = (FPW > 1) ? $clog2(FPW) : 1;
  localparam int unsigned CW     = FIFO_AW + 1;

  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  scan_done_q;

  logic [PORT_WIDTH-1:0] slot_q [SLOTS];
  logic [FILL_W-1:0]     fill_q [SLOTS];
  logic [PORT_WIDTH-1:0] fpack_q;
  logic [FCW-1:0]        fcnt_q;

  logic [PORT_WIDTH-1:0] d_mem [DEPTH];
  logic [FIFO_AW-1:0]    d_wr_q, d_rd_q;
  logic [CW-1:0]         d_cnt_q;
  logic [PORT_WIDTH-1:0] f_mem [DEPTH];
  logic [FIFO_AW-1:0]    f_wr_q, f_rd_q;
  logic [CW-1:0]         f_cnt_q;

  logic                  d_full, f_full, d_push, d_pop, f_push, f_pop;
  logic                  byte_acc, byte_done, flg_acc, flg_done;
  logic                  flush_slot, flush_flg, scan_adv;
  logic [PORT_WIDTH-1:0] byte_word, flush_word, flag_word, d_push_data, f_push_data;

  assign d_full     = d_cnt_q == CW'(DEPTH);
  assign f_full     = f_cnt_q == CW'(DEPTH);
  assign BF_rdy     = (state_q == StRun) && !d_full;
  assign BF_flg_rdy = (state_q == StRun) && !f_full;
  assign byte_acc   = BF_val && BF_rdy;
  assign byte_done  = fill_q[BF_addr] == FILL_W'(LANES - 2);
  assign flg_acc    = BF_flg_val && BF_flg_rdy;
  assign flg_done   = fcnt_q == FCW'(FPW - 1);

  // A full FIFO stalls the scan on a non-empty slot; empty slots are skipped regardless.
  assign flush_slot = (state_q == StFlush) && !scan_done_q && (fill_q[ptr_q] != '0) && !d_full;
  assign scan_adv   = (state_q == StFlush) && !scan_done_q && ((fill_q[ptr_q] == '0) || !d_full);
  assign flush_flg  = (state_q == StFlush) && (fcnt_q != '0) && !f_full;

  always_comb begin
    byte_word = slot_q[BF_addr];
    byte_word[(int'(fill_q[BF_addr]) + 1) * DATA_WIDTH +: DATA_WIDTH] = BF_data;
    byte_word[DATA_WIDTH-1:0] = DATA_WIDTH'(BF_addr);
    flush_word = slot_q[ptr_q];
    flush_word[DATA_WIDTH-1:0] = DATA_WIDTH'(ptr_q);
    flag_word = fpack_q;
    flag_word[(FPW - 1 - int'(fcnt_q)) * FLAG_WIDTH +: FLAG_WIDTH] = BF_flg_data;
  end

  assign d_push      = (byte_acc && byte_done) || flush_slot;
  assign d_push_data = flush_slot ? flush_word : byte_word;
  assign f_push      = (flg_acc && flg_done) || flush_flg;
  assign f_push_data = flush_flg ? fpack_q : flag_word;

  assign POOLIF_val      = (state_q == StRun) ? (d_cnt_q >= CW'(BURST)) : (d_cnt_q != '0);
  assign POOLIF_flg_val  = f_cnt_q != '0;
  assign POOLIF_data     = (d_cnt_q != '0) ? d_mem[d_rd_q] : '0;
  assign POOLIF_flg_data = (f_cnt_q != '0) ? f_mem[f_rd_q] : '0;
  assign d_pop           = POOLIF_val && IFPOOL_rdy;
  assign f_pop           = POOLIF_flg_val && IFPOOL_flg_rdy;
  assign clear_up        = (state_q == StDrain) && (d_cnt_q == '0) && (f_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      ptr_q       <= '0;
      scan_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (layer_fnh) begin
            state_q     <= StFlush;
            ptr_q       <= '0;
            scan_done_q <= 1'b0;
          end
        end
        StFlush: begin
          if (scan_adv) begin
            if (ptr_q == ADDR_WIDTH'(SLOTS - 1)) scan_done_q <= 1'b1;
            ptr_q <= ptr_q + ADDR_WIDTH'(1);
          end
          if (scan_done_q && (fcnt_q == '0)) state_q <= StDrain;
        end
        StDrain: begin
          scan_done_q <= 1'b0;
          if (clear_up) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      if (byte_acc) begin
        if (byte_done) begin
          slot_q[BF_addr] <= '0;
          fill_q[BF_addr] <= '0;
        end else begin
          slot_q[BF_addr] <= byte_word;
          fill_q[BF_addr] <= fill_q[BF_addr] + FILL_W'(1);
        end
      end
      if (flush_slot) begin
        slot_q[ptr_q] <= '0;
        fill_q[ptr_q] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpack_q <= '0;
      fcnt_q  <= '0;
    end else if (flush_flg || (flg_acc && flg_done)) begin
      fpack_q <= '0;
      fcnt_q  <= '0;
    end else if (flg_acc) begin
      fpack_q <= flag_word;
      fcnt_q  <= fcnt_q + FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (d_push) d_mem[d_wr_q] <= d_push_data;
    if (f_push) f_mem[f_wr_q] <= f_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_wr_q  <= '0;
      d_rd_q  <= '0;
      d_cnt_q <= '0;
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
    end else begin
      if (d_push) d_wr_q <= d_wr_q + FIFO_AW'(1);
      if (d_pop)  d_rd_q <= d_rd_q + FIFO_AW'(1);
      if (d_push && !d_pop)      d_cnt_q <= d_cnt_q + CW'(1);
      else if (!d_push && d_pop) d_cnt_q <= d_cnt_q - CW'(1);
      if (f_push) f_wr_q <= f_wr_q + FIFO_AW'(1);
      if (f_pop)  f_rd_q <= f_rd_q + FIFO_AW'(1);
      if (f_push && !f_pop)      f_cnt_q <= f_cnt_q + CW'(1);
      else if (!f_push && f_pop) f_cnt_q <= f_cnt_q - CW'(1);
    end
  end

`ifdef POOL_PACK_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (clear_up) begin
      blk_cnt <= '0;
    end else if (d_pop && (blk_cnt != 16'hFFFF)) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_pack_out.sv
// Randomized bench for pool_pack_out with a queue-based reference model and directed scenarios.
module tb_pool_pack_out;
  localparam int PW = 128, DW = 8, FW = 32, AW = 4, FAW = 6, BURST = 4;
  localparam int LANES = PW / DW, FPW = PW / FW, SLOTS = 1 << AW, DEPTH = 1 << FAW;

  logic          clk = 1'b0, rst_n = 1'b0, layer_fnh = 1'b0, clear_up;
  logic          BF_val = 1'b0, BF_rdy, BF_flg_val = 1'b0, BF_flg_rdy;
  logic [AW-1:0] BF_addr = '0;
  logic [DW-1:0] BF_data = '0;
  logic [FW-1:0] BF_flg_data = '0;
  logic          POOLIF_val, IFPOOL_rdy = 1'b0, POOLIF_flg_val, IFPOOL_flg_rdy = 1'b0;
  logic [PW-1:0] POOLIF_data, POOLIF_flg_data;
`ifdef POOL_PACK_CNT_EN
  logic [15:0]   blk_cnt;
  int            blk_exp = 0;
`endif

  always #5 clk = ~clk;

  pool_pack_out #(
    .PORT_WIDTH(PW), .DATA_WIDTH(DW), .FLAG_WIDTH(FW),
    .ADDR_WIDTH(AW), .FIFO_AW(FAW), .BURST(BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .layer_fnh(layer_fnh), .clear_up(clear_up),
    .BF_val(BF_val), .BF_rdy(BF_rdy), .BF_addr(BF_addr), .BF_data(BF_data),
    .BF_flg_val(BF_flg_val), .BF_flg_rdy(BF_flg_rdy), .BF_flg_data(BF_flg_data),
    .POOLIF_val(POOLIF_val), .IFPOOL_rdy(IFPOOL_rdy), .POOLIF_data(POOLIF_data),
    .POOLIF_flg_val(POOLIF_flg_val), .IFPOOL_flg_rdy(IFPOOL_flg_rdy),
    .POOLIF_flg_data(POOLIF_flg_data)
`ifdef POOL_PACK_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  // Reference model: expected FIFO contents in order, bytes held per slot, pending flags.
  logic [PW-1:0] dq[$], fq[$];
  logic [DW-1:0] slot_b [SLOTS][LANES];
  int            slot_n [SLOTS];
  logic [FW-1:0] flg_b [FPW];
  int            flg_n = 0;
  bit            run_ph = 1'b1;
  int            n_cmp = 0, n_fail = 0, n_clear = 0, flush_cyc = 0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk_word(input int a);
    logic [PW-1:0] w = '0;
    w[DW-1:0] = DW'(a);
    for (int k = 0; k < slot_n[a]; k++) w[(k + 1) * DW +: DW] = slot_b[a][k];
    return w;
  endfunction

  function automatic logic [PW-1:0] mk_flag();
    logic [PW-1:0] w = '0;
    for (int k = 0; k < flg_n; k++) w[(FPW - 1 - k) * FW +: FW] = flg_b[k];
    return w;
  endfunction

  always @(negedge clk) begin
    bit was_run, exp_brdy, exp_frdy;
    int a;
    if (!rst_n) begin
      chk("rst_clear_up", clear_up, 0);
      chk("rst_val", POOLIF_val, 0);
      chk("rst_flg_val", POOLIF_flg_val, 0);
      chk("rst_data", POOLIF_data, 0);
      chk("rst_flg_data", POOLIF_flg_data, 0);
      chk("rst_bf_rdy", BF_rdy, 1);
      chk("rst_bf_flg_rdy", BF_flg_rdy, 1);
      dq.delete();
      fq.delete();
      for (int i = 0; i < SLOTS; i++) slot_n[i] = 0;
      flg_n = 0;
      run_ph = 1'b1;
      flush_cyc = 0;
`ifdef POOL_PACK_CNT_EN
      blk_exp = 0;
`endif
    end else begin
      was_run  = run_ph;
      exp_brdy = run_ph && (dq.size() < DEPTH);
      exp_frdy = run_ph && (fq.size() < DEPTH);
      chk("bf_rdy", BF_rdy, exp_brdy);
      chk("bf_flg_rdy", BF_flg_rdy, exp_frdy);
`ifdef POOL_PACK_CNT_EN
      chk("blk_cnt", blk_cnt, blk_exp);
`endif
      if (run_ph) begin
        chk("val", POOLIF_val, dq.size() >= BURST);
        chk("flg_val", POOLIF_flg_val, fq.size() > 0);
        chk("data", POOLIF_data, (dq.size() > 0) ? dq[0] : '0);
        chk("flg_data", POOLIF_flg_data, (fq.size() > 0) ? fq[0] : '0);
        chk("clear_up_run", clear_up, 0);
      end else begin
        if (POOLIF_val) begin
          chk("flush_val_nonempty", dq.size() > 0, 1);
          if (dq.size() > 0) chk("flush_data", POOLIF_data, dq[0]);
        end
        if (POOLIF_flg_val) begin
          chk("flush_flg_nonempty", fq.size() > 0, 1);
          if (fq.size() > 0) chk("flush_flg_data", POOLIF_flg_data, fq[0]);
        end
        flush_cyc++;
        if (clear_up) begin
          chk("clear_up_left", dq.size() + fq.size(), 0);
          chk("clear_up_val", {POOLIF_val, POOLIF_flg_val}, 0);
          run_ph = 1'b1;
          n_clear++;
          flush_cyc = 0;
`ifdef POOL_PACK_CNT_EN
          blk_exp = -1;
`endif
        end else if (flush_cyc > 3000) begin
          chk("flush_timeout", flush_cyc, 0);
          flush_cyc = 0;
        end
      end
`ifdef POOL_PACK_CNT_EN
      if (blk_exp < 0) blk_exp = 0;
      else if (POOLIF_val && IFPOOL_rdy && blk_exp < 16'hFFFF) blk_exp++;
`endif
      if (POOLIF_val && IFPOOL_rdy && dq.size() > 0) void'(dq.pop_front());
      if (POOLIF_flg_val && IFPOOL_flg_rdy && fq.size() > 0) void'(fq.pop_front());
      if (BF_val && exp_brdy) begin
        a = int'(BF_addr);
        slot_b[a][slot_n[a]] = BF_data;
        slot_n[a]++;
        if (slot_n[a] == LANES - 1) begin
          dq.push_back(mk_word(a));
          slot_n[a] = 0;
        end
      end
      if (BF_flg_val && exp_frdy) begin
        flg_b[flg_n] = BF_flg_data;
        flg_n++;
        if (flg_n == FPW) begin
          fq.push_back(mk_flag());
          flg_n = 0;
        end
      end
      if (layer_fnh && was_run) begin
        run_ph = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
          if (slot_n[i] > 0) begin
            dq.push_back(mk_word(i));
            slot_n[i] = 0;
          end
        end
        if (flg_n > 0) begin
          fq.push_back(mk_flag());
          flg_n = 0;
        end
      end
    end
  end

  // Stimulus changes always happen 1 time unit after a rising edge.
  task automatic send_byte(input int a, input int d);
    bit ok = 1'b0;
    BF_addr = AW'(a);
    BF_data = DW'(d);
    BF_val  = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = BF_rdy;
      @(posedge clk);
      #1;
    end
    BF_val = 1'b0;
    if (!ok) chk("send_byte_timeout", 0, 1);
  endtask

  task automatic send_flag(input logic [FW-1:0] f);
    bit ok = 1'b0;
    BF_flg_data = f;
    BF_flg_val  = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = BF_flg_rdy;
      @(posedge clk);
      #1;
    end
    BF_flg_val = 1'b0;
    if (!ok) chk("send_flag_timeout", 0, 1);
  endtask

  task automatic pulse_fnh();
    layer_fnh = 1'b1;
    @(posedge clk);
    #1 layer_fnh = 1'b0;
  endtask

  task automatic wait_clear();
    int c0 = n_clear;
    for (int i = 0; i < 3000 && n_clear == c0; i++) @(posedge clk);
    #1;
    if (n_clear == c0) chk("clear_up_timeout", n_clear, c0 + 1);
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // One full slot: lane0 = address, lane k = k.
    for (int k = 1; k <= 15; k++) send_byte(3, k);
    @(negedge clk);
    chk("word_addr3", POOLIF_data, 128'h0F0E0D0C_0B0A0908_07060504_03020103);
    chk("model_addr3", dq[0], 128'h0F0E0D0C_0B0A0908_07060504_03020103);
    chk("burst_1word", POOLIF_val, 0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 15; k++) send_byte(5, 16 * 5 + k);
    for (int k = 1; k <= 15; k++) send_byte(6, 16 * 6 + k);
    @(negedge clk);
    chk("burst_3words", POOLIF_val, 0);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 15; k++) send_byte(9, 16 * 9 + k);
    @(negedge clk);
    chk("burst_4words", POOLIF_val, 1);
    @(posedge clk);
    #1;

    // Flag packing, then a partial word on layer end.
    send_flag(32'hA1A1A1A1);
    send_flag(32'hB2B2B2B2);
    send_flag(32'hC3C3C3C3);
    send_flag(32'hD4D4D4D4);
    @(negedge clk);
    chk("flag_word", POOLIF_flg_data, 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4);
    chk("model_flag", fq[0], 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4);
    @(posedge clk);
    #1 IFPOOL_flg_rdy = 1'b1;
    @(posedge clk);
    #1 IFPOOL_flg_rdy = 1'b0;
    send_flag(32'hE5E5E5E5);
    send_flag(32'hF6F6F6F6);
    pulse_fnh();
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("flag_partial", POOLIF_flg_data, 128'hE5E5E5E5_F6F6F6F6_00000000_00000000);
    chk("flag_partial_val", POOLIF_flg_val, 1);
    @(posedge clk);
    #1;
    IFPOOL_rdy = 1'b1;
    IFPOOL_flg_rdy = 1'b1;
    wait_clear();

    // Partial slots flush in address order, zero-padded.
    IFPOOL_rdy = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(7, 8'h71 + k);
    for (int k = 0; k < 3; k++) send_byte(2, 8'h21 + k);
    c0 = n_clear;
    pulse_fnh();
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("flush_addr2", POOLIF_data, 128'h23222102);
    @(posedge clk);
    #1 IFPOOL_rdy = 1'b1;
    @(posedge clk);
    #1 IFPOOL_rdy = 1'b0;
    @(negedge clk);
    chk("flush_addr7", POOLIF_data, 128'h757473727107);
    @(posedge clk);
    #1 IFPOOL_rdy = 1'b1;
    wait_clear();
    repeat (20) @(posedge clk);
    chk("clear_up_once", n_clear - c0, 1);

    // Fill the data FIFO to depth, then release a single word.
    #1 IFPOOL_rdy = 1'b0;
    for (int w = 0; w < DEPTH; w++)
      for (int k = 0; k < 15; k++) send_byte(w % SLOTS, w + k);
    @(negedge clk);
    chk("full_bf_rdy", BF_rdy, 0);
    @(posedge clk);
    #1 IFPOOL_rdy = 1'b1;
    @(posedge clk);
    #1 IFPOOL_rdy = 1'b0;
    @(negedge clk);
    chk("after_pop_bf_rdy", BF_rdy, 1);
    @(posedge clk);
    #1;

    // Reset while draining discards everything without clear_up.
    IFPOOL_rdy = 1'b1;
    pulse_fnh();
    repeat (25) @(posedge clk);
    #1 IFPOOL_rdy = 1'b0;
    c0 = n_clear;
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_clear_up", n_clear, c0);
    chk("rst_empty_val", {POOLIF_val, POOLIF_flg_val}, 0);
    @(posedge clk);
    #1;

    // Randomized traffic with occasional layer ends and back-pressure.
    for (int c = 0; c < 5000; c++) begin
      BF_val         = $urandom_range(0, 3) != 0;
      BF_addr        = AW'($urandom_range(0, SLOTS - 1));
      BF_data        = DW'($urandom);
      BF_flg_val     = $urandom_range(0, 2) == 0;
      BF_flg_data    = $urandom;
      IFPOOL_rdy     = $urandom_range(0, 2) != 0;
      IFPOOL_flg_rdy = $urandom_range(0, 3) != 0;
      layer_fnh      = $urandom_range(0, 299) == 0;
      @(posedge clk);
      #1;
    end
    BF_val = 1'b0;
    BF_flg_val = 1'b0;
    layer_fnh = 1'b0;
    IFPOOL_rdy = 1'b1;
    IFPOOL_flg_rdy = 1'b1;
    for (int i = 0; i < 3000 && !run_ph; i++) @(posedge clk);
    #1;
    pulse_fnh();
    wait_clear();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_pack_out.md
POOL_PACK_OUT -- requirements
Module: pool_pack_out

Interface
REQ-001 SHALL have parameter PORT_WIDTH, default 128: output word width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: input byte width; LANES = PORT_WIDTH/DATA_WIDTH.
REQ-003 SHALL have parameter FLAG_WIDTH, default 32: input flag width; FPW = PORT_WIDTH/FLAG_WIDTH.
REQ-004 SHALL have parameter ADDR_WIDTH, default 4: slot address width, 2^ADDR_WIDTH slots, ADDR_WIDTH <= DATA_WIDTH.
REQ-005 SHALL have parameter FIFO_AW, default 6: data and flag FIFO depth 2^FIFO_AW each.
REQ-006 SHALL have parameter BURST, default 1: minimum data FIFO occupancy before POOLIF_val asserts in RUN, 1..2^FIFO_AW.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 layer_fnh  in  1  single-cycle layer-end pulse.
REQ-010 clear_up  out  1  single-cycle pulse: layer fully flushed.
REQ-011 BF_val / BF_rdy  in / out  1 / 1  byte input handshake.
REQ-012 BF_addr  in  ADDR_WIDTH  slot index; BF_data  in  DATA_WIDTH  byte.
REQ-013 BF_flg_val / BF_flg_rdy  in / out  1 / 1  flag handshake; BF_flg_data  in  FLAG_WIDTH.
REQ-014 POOLIF_val / IFPOOL_rdy  out / in  1 / 1  data output handshake; POOLIF_data  out  PORT_WIDTH.
REQ-015 POOLIF_flg_val / IFPOOL_flg_rdy  out / in  1 / 1  flag output handshake; POOLIF_flg_data  out  PORT_WIDTH.

Function
REQ-016 Transfer on any port SHALL occur in a cycle where val and rdy are both high.
REQ-017 Each slot SHALL hold up to LANES-1 bytes plus a fill count; accepted byte goes to lane fill+1 of slot BF_addr, fill increments.
REQ-018 Byte completing a slot (fill = LANES-2 before) SHALL push {lanes LANES-1..1, lane0 = BF_addr zero-extended} into data FIFO in the same cycle; slot fill returns to 0.
REQ-019 BF_rdy SHALL = (state == RUN) && data FIFO not full.
REQ-020 Flags SHALL be packed FPW per word, first accepted flag in most significant FLAG_WIDTH bits; completed word pushed to flag FIFO in the completing cycle.
REQ-021 BF_flg_rdy SHALL = (state == RUN) && flag FIFO not full.
REQ-022 FIFOs SHALL be first-word-fall-through: POOLIF_data / POOLIF_flg_data show head entry combinationally, 0 when empty.
REQ-023 POOLIF_val SHALL = data count >= BURST in RUN, data count > 0 in FLUSH/DRAIN; POOLIF_flg_val SHALL = flag count > 0 in all states.
REQ-024 FSM states RUN, FLUSH, DRAIN; RUN -> FLUSH on layer_fnh; layer_fnh outside RUN ignored.
REQ-025 FLUSH SHALL scan slot pointer 0..2^ADDR_WIDTH-1, one slot per cycle; slot with fill > 0 pushes word with unused lanes zero; pointer holds while data FIFO full.
REQ-026 In first FLUSH cycle a partial flag word (1..FPW-1 flags) SHALL be pushed with remaining positions zero; retried each cycle while flag FIFO full.
REQ-027 FLUSH -> DRAIN after last slot handled and partial flag pushed; DRAIN -> RUN when both FIFOs empty, asserting clear_up for exactly that cycle.
REQ-028 Simultaneous push and pop on a FIFO SHALL leave count unchanged; pop on empty or push on full SHALL never occur.
REQ-029 Byte to a slot never wraps: slot completion always precedes the LANES-th byte.

Reset
REQ-030 On rst_n low: state RUN, all slot fills, flag pack count, FIFO pointers/counts, scan pointer zero; all outputs 0 except BF_rdy and BF_flg_rdy which reflect RUN with empty FIFOs (1) once rst_n is released.
REQ-031 Reset mid-FLUSH/DRAIN SHALL discard all buffered data without clear_up.

Configuration
REQ-032 Macro POOL_PACK_CNT_EN: when defined, output port blk_cnt  out  16 SHALL count data words popped since last clear_up (cleared the cycle after clear_up, saturating at 16'hFFFF); when undefined the port and counter SHALL not exist.

Verification
REQ-033 LANES=16: 15 bytes 1..15 to addr 3, IFPOOL_rdy=1 -> one word, lane0=3, lane k = k.
REQ-034 4 flags A,B,C,D -> one flag word {A,B,C,D}; then 2 flags E,F + layer_fnh -> word {E,F,0,0}, then clear_up.
REQ-035 5 bytes to addr 7, 3 bytes to addr 2, layer_fnh -> words for addr 2 then 7, zero-padded, then clear_up single pulse.
REQ-036 IFPOOL_rdy=0, fill data FIFO to 64 -> BF_rdy=0; rdy=1 one cycle -> one pop, BF_rdy=1 next cycle.
REQ-037 BURST=4: 3 completed words -> POOLIF_val=0; 4th -> POOLIF_val=1; layer_fnh with 2 words -> both drained.
REQ-038 rst_n low during DRAIN -> all outputs 0, no clear_up, FIFOs empty after release.
